cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
Two-port front-end controller that shares the single-cycle direct-mapped cache between two requesters (e.g. instruction and data side).
- After reset it runs an initialization sweep that writes an invalid, zeroed row to every set. The cache has no built-in initialization.
- In normal operation it grants at most one request per cycle, round-robin, and drives the cache put interface.
- It captures the cache's same-cycle row into a per-port one-entry response buffer and computes a hit flag.

Parameters:
INDEX_W, 12, cache index width; the sweep covers 2^INDEX_W sets.
INIT_SWEEP, 1, 1 = run the reset sweep; 0 = enter RUN directly after reset.

Ports:
CLK  input  1  clock
RST_N  input  1  reset, synchronous, active-low
init_done  output  1  high once in RUN state
req_valid_0 / req_valid_1  input  1  request valid, port 0 / port 1
req_ready_0 / req_ready_1  output  1  request accepted this cycle (grant)
req_0 / req_1  input  69  packed request {byte_en[4], tag[18], index[12], data[32], msi_valid[1], msi[2]}
resp_valid_0 / resp_valid_1  output  1  response buffer holds a row
resp_ready_0 / resp_ready_1  input  1  requester consumes the response
resp_row_0 / resp_row_1  output  53  pre-write row {1'b0, tag[18], data[32], msi[2]}
resp_hit_0 / resp_hit_1  output  1  row tag == request tag && row msi != 2'b00
cache_put_valid  output  1  cache request strobe
cache_put_request  output  69  packed request to cache, same format as req_*
cache_get_response  input  53  cache row at put_request index, combinational, pre-write

Behaviour:
- Reset (RST_N==0 at a posedge):
  - state <= INIT if INIT_SWEEP else RUN; sweep counter <= 0; rr_ptr <= 0 (port 0 preferred).
  - resp_valid_* <= 0; resp_row_* <= 0; resp_hit_* <= 0.
  - Reset mid-operation discards buffered responses and restarts the sweep at index 0.
- INIT:
  - Every cycle: cache_put_valid=1, cache_put_request={4'b1111, 18'h0, ctr, 32'h0, 1'b1, 2'b00}; ctr++.
  - The cycle issuing ctr==2^INDEX_W-1 transitions to RUN. The sweep lasts exactly 2^INDEX_W cycles.
  - req_ready_* = 0 and init_done = 0 throughout INIT.
- RUN:
  - init_done=1.
  - eligible_i = req_valid_i && (!resp_valid_i || resp_ready_i).
  - Grant: if both ports are eligible, grant port rr_ptr; otherwise grant the single eligible port; otherwise no grant.
  - req_ready_i = grant_i. Ready is combinational from valid; requesters must not make valid depend on ready.
  - cache_put_valid = |grant; cache_put_request = granted port's req. When idle, cache_put_valid=0 and cache_put_request=0.
  - On grant to port i at a posedge: resp_valid_i <= 1; resp_row_i <= cache_get_response; resp_hit_i <= hit as defined above. rr_ptr <= ~i, updated on every grant.
  - Drain: resp_valid_i && resp_ready_i with no new grant to i clears resp_valid_i. Drain plus re-grant in the same cycle reloads the buffer, allowing 1 req/cycle per port.
  - Response latency is 1 cycle: the row becomes visible the cycle after acceptance.
  - The row returned is the contents before the write. A write's effect is seen by the next request to that index.
- Miss handling and refill are outside this block; only resp_hit is reported.
- Aggregate throughput is 1 request/cycle; starvation is impossible under contention.

Decomposition:
- Package cache_pkg holds:
  - width constants BYTE_EN_W=4, TAG_W=18, DATA_W=32, MSI_W=2, REQ_W=69, ROW_W=53;
  - MSI encodings MSI_I=2'b00, MSI_S=2'b01, MSI_M=2'b11;
  - packed struct typedefs cache_req_t and cache_row_t;
  - state enum {INIT, RUN}.
- One sub-module, cache_resp_buffer: a one-entry valid/ready holding register, instantiated per port.

Test Plan:
1. Sweep: reset with INIT_SWEEP=1.
   - Expect 4096 consecutive puts with index 0..4095, byte_en 1111, msi_valid 1, msi 00.
   - init_done rises in cycle 4096; req_ready_* stays 0 until then.
2. Read after sweep: port0 req byte_en 0, tag 0x00001, index 5.
   - Next cycle: resp_valid_0=1, row tag 0, data 0, msi 00, resp_hit_0=0.
3. Write/read on port0:
   - Write byte_en 1111, tag 0x0002A, index 7, data 0xDEADBEEF, msi_valid 1, msi 11 → resp_hit_0=0 (pre-write row).
   - Write byte_en 0011, data 0x00001234 → row data 0xDEADBEEF, hit 1.
   - Read tag 0x0002A, index 7 → data 0xDEAD1234, msi 11, hit 1.
4. Contention: both req_valid held 1, resp_ready 1 for 6 cycles → grants 0,1,0,1,0,1; cache_put_valid=1 every cycle.
5. Backpressure: port0 resp_valid_0=1 with resp_ready_0=0.
   - req_ready_0=0 and port1 wins every cycle.
   - Raise resp_ready_0 → port0 drains and is re-granted the same cycle when rr_ptr==0.
6. Reset mid-run: RST_N=0 for one cycle with both responses pending.
   - Next cycle: resp_valid_*=0, init_done=0, sweep restarts at index 0.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, MSI encodings, request/row layouts and arbiter state for the cache front end
package cache_pkg;
  localparam int BYTE_EN_W = 4;
  localparam int TAG_W     = 18;
  localparam int IDX_W     = 12;
  localparam int DATA_W    = 32;
  localparam int MSI_W     = 2;
  localparam int REQ_W     = 69;
  localparam int ROW_W     = 53;
  localparam logic [MSI_W-1:0] MSI_I = 2'b00;
  localparam logic [MSI_W-1:0] MSI_S = 2'b01;
  localparam logic [MSI_W-1:0] MSI_M = 2'b11;
  typedef struct packed {
    logic [BYTE_EN_W-1:0] byte_en;
    logic [TAG_W-1:0]     tag;
    logic [IDX_W-1:0]     index;
    logic [DATA_W-1:0]    data;
    logic                 msi_valid;
    logic [MSI_W-1:0]     msi;
  } cache_req_t;
  typedef struct packed {
    logic                 pad;
    logic [TAG_W-1:0]     tag;
    logic [DATA_W-1:0]    data;
    logic [MSI_W-1:0]     msi;
  } cache_row_t;
  typedef enum logic {INIT, RUN} state_e;
  function automatic logic row_hit(cache_row_t row, cache_req_t req);
    return row.tag == req.tag && row.msi != MSI_I;
  endfunction
endpackage

// File: rtl/cache_resp_buffer.sv
// cache_resp_buffer: one-entry valid/ready holding register for a captured cache row and its hit flag
module cache_resp_buffer
  import cache_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       load,
  input  logic       rdy,
  input  cache_row_t row_in,
  input  logic       hit_in,
  output logic       valid,
  output cache_row_t row,
  output logic       hit
);
  logic       valid_q, valid_d, hit_q, hit_d;
  cache_row_t row_q, row_d;
  // a load wins over a drain so drain and refill can share one cycle
  always_comb begin
    valid_d = load || (valid_q && !rdy);
    row_d   = load ? row_in : row_q;
    hit_d   = load ? hit_in : hit_q;
  end
  // entry registers, cleared on reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      row_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
      hit_q   <= hit_d;
    end
  end
  assign valid = valid_q;
  assign row   = row_q;
  assign hit   = hit_q;
endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: sweeps the cache invalid after reset, then round-robin shares it between two ports
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int   INDEX_W    = 12,
  parameter logic INIT_SWEEP = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  output logic             init_done,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [REQ_W-1:0] req_0,
  input  logic [REQ_W-1:0] req_1,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  input  logic             resp_ready_0,
  input  logic             resp_ready_1,
  output logic [ROW_W-1:0] resp_row_0,
  output logic [ROW_W-1:0] resp_row_1,
  output logic             resp_hit_0,
  output logic             resp_hit_1,
  output logic             cache_put_valid,
  output logic [REQ_W-1:0] cache_put_request,
  input  logic [ROW_W-1:0] cache_get_response
);
  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   ctr_q, ctr_d;
  logic                 rr_q, rr_d;
  logic                 run, elig_0, elig_1, grant_0, grant_1, hit;
  cache_req_t           sweep_req, put_req;
  assign run = state_q == RUN;
  // sweep request, eligibility, round-robin grant and next-state computation
  always_comb begin
    sweep_req = '{byte_en: '1, tag: '0, index: IDX_W'(ctr_q), data: '0, msi_valid: 1'b1, msi: MSI_I};
    elig_0    = run && req_valid_0 && (!resp_valid_0 || resp_ready_0);
    elig_1    = run && req_valid_1 && (!resp_valid_1 || resp_ready_1);
    grant_0   = elig_0 && (!elig_1 || !rr_q);
    grant_1   = elig_1 && (!elig_0 || rr_q);
    put_req   = !run ? sweep_req : grant_0 ? cache_req_t'(req_0) : grant_1 ? cache_req_t'(req_1) : '0;
    hit       = row_hit(cache_row_t'(cache_get_response), put_req);
    rr_d      = grant_0 ? 1'b1 : grant_1 ? 1'b0 : rr_q;
    ctr_d     = run ? ctr_q : ctr_q + INDEX_W'(1);
    state_d   = (!run && &ctr_q) ? RUN : state_q;
  end
  // controller state: mode, sweep index and round-robin pointer
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= INIT_SWEEP ? INIT : RUN;
      ctr_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rr_q    <= rr_d;
    end
  end
  assign init_done         = run;
  assign req_ready_0       = grant_0;
  assign req_ready_1       = grant_1;
  assign cache_put_valid   = !run || grant_0 || grant_1;
  assign cache_put_request = put_req;
  cache_resp_buffer u_buf_0 (
    .CLK(CLK), .RST_N(RST_N), .load(grant_0), .rdy(resp_ready_0),
    .row_in(cache_get_response), .hit_in(hit),
    .valid(resp_valid_0), .row(resp_row_0), .hit(resp_hit_0)
  );
  cache_resp_buffer u_buf_1 (
    .CLK(CLK), .RST_N(RST_N), .load(grant_1), .rdy(resp_ready_1),
    .row_in(cache_get_response), .hit_in(hit),
    .valid(resp_valid_1), .row(resp_row_1), .hit(resp_hit_1)
  );
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: randomized scoreboard bench with a behavioural cache and arbitration model
module tb_cache_port_arbiter;
  import cache_pkg::*;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;
  logic             rqv [2];
  logic             rsr [2];
  cache_req_t       rq  [2];
  logic             rqr [2];
  logic             rv  [2];
  logic             rh  [2];
  cache_row_t       rrow[2];
  logic             init_done, cache_put_valid;
  logic [REQ_W-1:0] cache_put_request;
  logic [ROW_W-1:0] cache_get_response;
  cache_req_t       put_r;
  cache_row_t       mem [4096];
  assign put_r = cache_put_request;
  assign cache_get_response = mem[put_r.index];
  cache_port_arbiter #(.INDEX_W(12), .INIT_SWEEP(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .init_done(init_done),
    .req_valid_0(rqv[0]), .req_valid_1(rqv[1]),
    .req_ready_0(rqr[0]), .req_ready_1(rqr[1]),
    .req_0(rq[0]), .req_1(rq[1]),
    .resp_valid_0(rv[0]), .resp_valid_1(rv[1]),
    .resp_ready_0(rsr[0]), .resp_ready_1(rsr[1]),
    .resp_row_0(rrow[0]), .resp_row_1(rrow[1]),
    .resp_hit_0(rh[0]), .resp_hit_1(rh[1]),
    .cache_put_valid(cache_put_valid), .cache_put_request(cache_put_request),
    .cache_get_response(cache_get_response)
  );
  typedef struct {cache_row_t row; logic hit;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   last = 1;
  int   last_grant = -1;
  logic occ[2];
  function automatic void chk(string name, logic [68:0] act, logic [68:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  function automatic cache_req_t mk(logic [3:0] be, logic [17:0] tag, logic [11:0] idx, logic [31:0] d, logic mv, logic [1:0] m);
    cache_req_t r;
    r = '{byte_en: be, tag: tag, index: idx, data: d, msi_valid: mv, msi: m};
    return r;
  endfunction
  function automatic cache_req_t rand_req();
    int k;
    k = $urandom_range(0, 2);
    return mk(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), 18'($urandom_range(1, 3)),
              12'($urandom_range(0, 7)), $urandom, 1'($urandom),
              (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11);
  endfunction
  task automatic drive(input logic v0, input cache_req_t r0, input logic v1, input cache_req_t r1, input logic s0, input logic s1);
    rqv[0] = v0; rq[0] = r0; rqv[1] = v1; rq[1] = r1; rsr[0] = s0; rsr[1] = s1;
  endtask
  // reference arbitration: eligible ports, alternate between them under contention
  task automatic model();
    logic     e[2];
    int       g;
    cache_req_t er;
    exp_t     x;
    for (int p = 0; p < 2; p++) e[p] = rqv[p] && (!occ[p] || rsr[p]);
    g = -1;
    if (e[0] && e[1]) g = 1 - last;
    else if (e[0]) g = 0;
    else if (e[1]) g = 1;
    er = '0;
    if (g >= 0) er = rq[g];
    chk("init_done_run", 69'(init_done), 69'(1));
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("req_ready_%0d", p), 69'(rqr[p]), 69'(g == p));
      chk($sformatf("resp_valid_%0d", p), 69'(rv[p]), 69'(occ[p]));
    end
    chk("put_valid", 69'(cache_put_valid), 69'(g >= 0));
    chk("put_request", 69'(cache_put_request), 69'(er));
    for (int p = 0; p < 2; p++)
      if (g == p) occ[p] = 1'b1;
      else if (occ[p] && rsr[p]) occ[p] = 1'b0;
    last_grant = g;
    if (g >= 0) begin
      x.row = mem[rq[g].index];
      x.hit = x.row.tag == rq[g].tag && x.row.msi != 2'b00;
      if (g == 0) q0.push_back(x); else q1.push_back(x);
      last = g;
    end
  endtask
  // one clock: check at negedge+1 (mode 1 sweep, mode 2 run), then apply the cache write at the edge
  task automatic step(input int mode, input int idx);
    cache_req_t pr;
    cache_row_t nw;
    logic       pv, wr;
    #1;
    pv = cache_put_valid;
    pr = cache_put_request;
    if (mode == 1) begin
      chk("sweep_put_valid", 69'(cache_put_valid), 69'(1));
      chk("sweep_put_request", 69'(cache_put_request), 69'(mk(4'hf, 18'h0, 12'(idx), 32'h0, 1'b1, 2'b00)));
      chk("sweep_ready_0", 69'(rqr[0]), 69'(0));
      chk("sweep_ready_1", 69'(rqr[1]), 69'(0));
      chk("sweep_init_done", 69'(init_done), 69'(0));
    end
    if (mode == 2) model();
    nw = mem[pr.index];
    wr = pr.byte_en != 4'h0 || pr.msi_valid;
    if (wr) begin
      nw.tag = pr.tag;
      for (int b = 0; b < 4; b++) if (pr.byte_en[b]) nw.data[8*b +: 8] = pr.data[8*b +: 8];
      if (pr.msi_valid) nw.msi = pr.msi;
    end
    @(posedge CLK);
    if (pv === 1'b1 && wr === 1'b1) mem[pr.index] <= nw;
    @(negedge CLK);
  endtask
  task automatic sweep();
    for (int i = 0; i < 4096; i++) begin
      drive(1'b1, rand_req(), 1'b1, rand_req(), 1'b1, 1'b1);
      step(1, i);
    end
    chk("init_done_after_sweep", 69'(init_done), 69'(1));
  endtask
  // monitor: every consumed response is checked against the oldest expected entry of its port
  initial forever begin
    exp_t x;
    logic have;
    @(negedge CLK);
    #2;
    for (int p = 0; p < 2; p++) begin
      if (rv[p] === 1'b1 && rsr[p] === 1'b1) begin
        have = (p == 0) ? q0.size() > 0 : q1.size() > 0;
        if (have) x = (p == 0) ? q0.pop_front() : q1.pop_front();
        if (!have) begin
          n_chk++;
          n_fail++;
          $display("FAIL resp_unexpected_%0d: got valid response, expected none", p);
        end else begin
          chk($sformatf("resp_row_%0d", p), 69'(rrow[p]), 69'(x.row));
          chk($sformatf("resp_hit_%0d", p), 69'(rh[p]), 69'(x.hit));
        end
      end
    end
  end
  initial begin
    logic [63:0] t;
    for (int i = 0; i < 4096; i++) begin
      t = {$urandom, $urandom};
      mem[i] = t[52:0];
    end
    occ[0] = 1'b0;
    occ[1] = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) step(0, 0);
    chk("reset_resp_valid_0", 69'(rv[0]), 69'(0));
    chk("reset_resp_valid_1", 69'(rv[1]), 69'(0));
    chk("reset_init_done", 69'(init_done), 69'(0));
    RST_N = 1'b1;
    sweep();
    drive(1'b1, mk(4'h0, 18'h1, 12'd5, 32'h0, 1'b0, 2'b00), 1'b0, '0, 1'b1, 1'b1);
    step(2, 0);
    chk("read5_valid", 69'(rv[0]), 69'(1));
    chk("read5_row", 69'(rrow[0]), 69'(0));
    chk("read5_hit", 69'(rh[0]), 69'(0));
    drive(1'b1, mk(4'hf, 18'h2A, 12'd7, 32'hDEADBEEF, 1'b1, 2'b11), 1'b0, '0, 1'b1, 1'b1);
    step(2, 0);
    chk("wr_full_hit", 69'(rh[0]), 69'(0));
    drive(1'b1, mk(4'h3, 18'h2A, 12'd7, 32'h00001234, 1'b0, 2'b00), 1'b0, '0, 1'b1, 1'b1);
    step(2, 0);
    chk("wr_part_data", 69'(rrow[0].data), 69'(32'hDEADBEEF));
    chk("wr_part_hit", 69'(rh[0]), 69'(1));
    drive(1'b1, mk(4'h0, 18'h2A, 12'd7, 32'h0, 1'b0, 2'b00), 1'b0, '0, 1'b1, 1'b1);
    step(2, 0);
    chk("rd7_data", 69'(rrow[0].data), 69'(32'hDEAD1234));
    chk("rd7_msi", 69'(rrow[0].msi), 69'(2'b11));
    chk("rd7_hit", 69'(rh[0]), 69'(1));
    drive(1'b0, '0, 1'b1, rand_req(), 1'b1, 1'b1);
    step(2, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, rand_req(), 1'b1, rand_req(), 1'b1, 1'b1);
      step(2, 0);
      chk("contention_grant", 69'(last_grant), 69'(i % 2));
    end
    drive(1'b1, rand_req(), 1'b0, '0, 1'b0, 1'b1);
    step(2, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rand_req(), 1'b1, rand_req(), 1'b0, 1'b1);
      step(2, 0);
      chk("backpressure_grant", 69'(last_grant), 69'(1));
    end
    drive(1'b1, rand_req(), 1'b1, rand_req(), 1'b1, 1'b1);
    step(2, 0);
    chk("drain_regrant", 69'(last_grant), 69'(0));
    chk("drain_regrant_valid", 69'(rv[0]), 69'(1));
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), rand_req(), 1'($urandom), rand_req(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      step(2, 0);
    end
    repeat (2) begin
      drive(1'b1, rand_req(), 1'b1, rand_req(), 1'b0, 1'b0);
      step(2, 0);
    end
    chk("pending_0", 69'(rv[0]), 69'(1));
    chk("pending_1", 69'(rv[1]), 69'(1));
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    RST_N = 1'b0;
    step(0, 0);
    q0.delete();
    q1.delete();
    occ[0] = 1'b0;
    occ[1] = 1'b0;
    last = 1;
    RST_N = 1'b1;
    chk("midreset_resp_valid_0", 69'(rv[0]), 69'(0));
    chk("midreset_resp_valid_1", 69'(rv[1]), 69'(0));
    chk("midreset_init_done", 69'(init_done), 69'(0));
    sweep();
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom), rand_req(), 1'($urandom), rand_req(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      step(2, 0);
    end
    repeat (3) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
      step(2, 0);
    end
    chk("drained_q0", 69'(q0.size()), 69'(0));
    chk("drained_q1", 69'(q1.size()), 69'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
